// File: rtl/alu_seq.sv
// Sequential ALU: single-cycle logic/arithmetic/shift ops plus a multi-cycle
// shift-add multiplier. Results and flags are registered and held between ops.
module alu_seq #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [3:0]       alu_op,
    input  logic [WIDTH-1:0] inA,
    input  logic [WIDTH-1:0] inB,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] alu_out,
    output logic             SKZ_cmp,
    output logic             carry,
    output logic             ovf
);

    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_AND = 4'b0011;
    localparam logic [3:0] OP_XOR = 4'b0100;
    localparam logic [3:0] OP_LDB = 4'b0101;
    localparam logic [3:0] OP_SUB = 4'b1000;
    localparam logic [3:0] OP_OR  = 4'b1001;
    localparam logic [3:0] OP_MUL = 4'b1010;
    localparam logic [3:0] OP_SHL = 4'b1011;
    localparam logic [3:0] OP_SHR = 4'b1100;

    localparam logic [5:0] CNT_LAST = 6'(WIDTH - 1);

    typedef enum logic {S_IDLE, S_MUL} state_t;

    state_t                 state_q, state_d;
    logic [2*WIDTH-1:0]     mcand_q, mcand_d;
    logic [WIDTH-1:0]       mplier_q, mplier_d;
    logic [2*WIDTH-1:0]     prod_q, prod_d;
    logic [5:0]             cnt_q, cnt_d;
    logic [WIDTH-1:0]       out_q, out_d;
    logic                   skz_q, skz_d;
    logic                   c_q, c_d;
    logic                   v_q, v_d;
    logic                   done_q, done_d;

    logic [WIDTH:0]         sum_w, dif_w, shl_w;
    logic [WIDTH-1:0]       r_res;
    logic                   r_c, r_v, r_z;
    logic [2*WIDTH-1:0]     prod_add;

    // Single-cycle datapath, evaluated straight from the request inputs.
    // The extra top bit of dif_w is the unsigned borrow; shl_w's top bit is the
    // last bit shifted out, which naturally reads 0 for B=0 and for B>WIDTH.
    always_comb begin
        sum_w = {1'b0, inA} + {1'b0, inB};
        dif_w = {1'b0, inA} - {1'b0, inB};
        shl_w = {1'b0, inA} << inB;
        r_res = inA;
        r_c   = 1'b0;
        r_v   = 1'b0;
        case (alu_op)
            OP_ADD: begin
                r_res = sum_w[WIDTH-1:0];
                r_c   = sum_w[WIDTH];
                r_v   = (inA[WIDTH-1] == inB[WIDTH-1]) && (sum_w[WIDTH-1] != inA[WIDTH-1]);
            end
            OP_SUB: begin
                r_res = dif_w[WIDTH-1:0];
                r_c   = dif_w[WIDTH];
                r_v   = (inA[WIDTH-1] != inB[WIDTH-1]) && (dif_w[WIDTH-1] != inA[WIDTH-1]);
            end
            OP_AND:  r_res = inA & inB;
            OP_XOR:  r_res = inA ^ inB;
            OP_LDB:  r_res = inB;
            OP_OR:   r_res = inA | inB;
            OP_SHL: begin
                r_res = shl_w[WIDTH-1:0];
                r_c   = shl_w[WIDTH];
            end
            OP_SHR:  r_res = inA >> inB;
            default: r_res = inA;
        endcase
        // The pass-through ops test the accumulator itself for the skip decision.
        if (alu_op == 4'b0000 || alu_op == 4'b0001 || alu_op == 4'b0110 || alu_op == 4'b0111)
            r_z = ~|inA;
        else
            r_z = ~|r_res;
    end

    assign prod_add = mplier_q[0] ? (prod_q + mcand_q) : prod_q;

    always_comb begin
        state_d  = state_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        prod_d   = prod_q;
        cnt_d    = cnt_q;
        out_d    = out_q;
        skz_d    = skz_q;
        c_d      = c_q;
        v_d      = v_q;
        done_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (alu_op == OP_MUL) begin
                        state_d  = S_MUL;
                        mcand_d  = {{WIDTH{1'b0}}, inA};
                        mplier_d = inB;
                        prod_d   = '0;
                        cnt_d    = '0;
                    end else begin
                        out_d  = r_res;
                        skz_d  = r_z;
                        c_d    = r_c;
                        v_d    = r_v;
                        done_d = 1'b1;
                    end
                end
            end
            S_MUL: begin
                prod_d   = prod_add;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + 6'd1;
                // Last multiplier bit: publish the product on this same edge.
                if (cnt_q == CNT_LAST) begin
                    state_d = S_IDLE;
                    out_d   = prod_add[WIDTH-1:0];
                    skz_d   = ~|prod_add[WIDTH-1:0];
                    c_d     = |prod_add[2*WIDTH-1:WIDTH];
                    v_d     = 1'b0;
                    done_d  = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            mcand_q  <= '0;
            mplier_q <= '0;
            prod_q   <= '0;
            cnt_q    <= '0;
            out_q    <= '0;
            skz_q    <= 1'b0;
            c_q      <= 1'b0;
            v_q      <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            prod_q   <= prod_d;
            cnt_q    <= cnt_d;
            out_q    <= out_d;
            skz_q    <= skz_d;
            c_q      <= c_d;
            v_q      <= v_d;
            done_q   <= done_d;
        end
    end

    assign busy    = (state_q == S_MUL);
    assign done    = done_q;
    assign alu_out = out_q;
    assign SKZ_cmp = skz_q;
    assign carry   = c_q;
    assign ovf     = v_q;

endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq (WIDTH=8): cycle-level reference model compared every cycle,
// plus directed vectors with hand-computed expectations.
module tb_alu_seq;

    localparam int W = 8;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [3:0]   alu_op;
    logic [W-1:0] inA, inB;
    logic         busy, done, SKZ_cmp, carry, ovf;
    logic [W-1:0] alu_out;

    int n_chk  = 0;
    int n_fail = 0;
    bit cmp_en = 0;

    alu_seq #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .alu_op(alu_op),
        .inA(inA), .inB(inB), .busy(busy), .done(done),
        .alu_out(alu_out), .SKZ_cmp(SKZ_cmp), .carry(carry), .ovf(ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference arithmetic on plain integers.
    function automatic int sx(input int a);
        return (a >= 128) ? a - 256 : a;
    endfunction

    function automatic int f_res(input int op, input int a, input int b);
        case (op)
            2:  return (a + b) & 255;
            3:  return a & b;
            4:  return a ^ b;
            5:  return b;
            8:  return (a - b) & 255;
            9:  return a | b;
            10: return (a * b) & 255;
            11: return (b >= 8) ? 0 : ((a << b) & 255);
            12: return (b >= 8) ? 0 : (a >> b);
            default: return a;
        endcase
    endfunction

    function automatic int f_c(input int op, input int a, input int b);
        case (op)
            2:  return (a + b > 255) ? 1 : 0;
            8:  return (a < b) ? 1 : 0;
            10: return (a * b > 255) ? 1 : 0;
            11: return (b >= 1 && b <= 8) ? ((a >> (8 - b)) & 1) : 0;
            default: return 0;
        endcase
    endfunction

    function automatic int f_v(input int op, input int a, input int b);
        int s;
        s = 0;
        if (op == 2) s = sx(a) + sx(b);
        if (op == 8) s = sx(a) - sx(b);
        return (s > 127 || s < -128) ? 1 : 0;
    endfunction

    function automatic int f_z(input int op, input int a, input int b);
        if (op == 0 || op == 1 || op == 6 || op == 7) return (a == 0) ? 1 : 0;
        return (f_res(op, a, b) == 0) ? 1 : 0;
    endfunction

    int m_busy = 0, m_done = 0, m_out = 0, m_skz = 0, m_c = 0, m_v = 0;
    int m_cnt = 0, m_a = 0, m_b = 0;

    // Cycle-level model: MUL takes W cycles from acceptance, then publishes a*b.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy <= 0; m_done <= 0; m_out <= 0; m_skz <= 0; m_c <= 0; m_v <= 0;
            m_cnt <= 0; m_a <= 0; m_b <= 0;
        end else begin
            m_done <= 0;
            if (m_busy != 0) begin
                m_cnt <= m_cnt - 1;
                if (m_cnt == 1) begin
                    m_busy <= 0;
                    m_done <= 1;
                    m_out  <= f_res(10, m_a, m_b);
                    m_c    <= f_c(10, m_a, m_b);
                    m_v    <= 0;
                    m_skz  <= f_z(10, m_a, m_b);
                end
            end else if (start) begin
                if (alu_op == 4'hA) begin
                    m_busy <= 1;
                    m_cnt  <= W;
                    m_a    <= int'(inA);
                    m_b    <= int'(inB);
                end else begin
                    m_done <= 1;
                    m_out  <= f_res(int'(alu_op), int'(inA), int'(inB));
                    m_c    <= f_c(int'(alu_op), int'(inA), int'(inB));
                    m_v    <= f_v(int'(alu_op), int'(inA), int'(inB));
                    m_skz  <= f_z(int'(alu_op), int'(inA), int'(inB));
                end
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("cmp.busy", 32'(busy), m_busy);
            chk("cmp.done", 32'(done), m_done);
            chk("cmp.alu_out", 32'(alu_out), m_out);
            chk("cmp.SKZ_cmp", 32'(SKZ_cmp), m_skz);
            chk("cmp.carry", 32'(carry), m_c);
            chk("cmp.ovf", 32'(ovf), m_v);
        end
    end

    task automatic lit(input string tag, input int o, input int c, input int v, input int z, input int d);
        chk({tag, ".alu_out"}, 32'(alu_out), o);
        chk({tag, ".carry"}, 32'(carry), c);
        chk({tag, ".ovf"}, 32'(ovf), v);
        chk({tag, ".SKZ_cmp"}, 32'(SKZ_cmp), z);
        chk({tag, ".done"}, 32'(done), d);
    endtask

    task automatic op1(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
        start = 1'b1; alu_op = op; inA = a; inB = b;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic run_mul(input logic [7:0] a, input logic [7:0] b, input bit inject,
                           output int nb, output int nd);
        nb = 0; nd = 0;
        start = 1'b1; alu_op = 4'hA; inA = a; inB = b;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 12; i++) begin
            if (busy) nb++;
            if (done) nd++;
            if (inject && i == 2) begin
                start = 1'b1; alu_op = 4'h2; inA = 8'h01; inB = 8'h01;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
        end
    endtask

    initial begin
        int nb, nd;
        logic [3:0] b2b_op [6] = '{4'h3, 4'h4, 4'h9, 4'hC, 4'hB, 4'hD};
        logic [7:0] b2b_a  [6] = '{8'hF0, 8'hF0, 8'hF0, 8'hF0, 8'h81, 8'h00};
        logic [7:0] b2b_b  [6] = '{8'h3C, 8'h3C, 8'h3C, 8'h04, 8'h01, 8'h77};
        logic [7:0] b2b_r  [6] = '{8'h30, 8'hCC, 8'hFC, 8'h0F, 8'h02, 8'h00};

        rst_n = 1'b1; start = 1'b0; alu_op = 4'h0; inA = '0; inB = '0;
        #1 rst_n = 1'b0;
        #1;
        lit("reset", 0, 0, 0, 0, 0);
        chk("reset.busy", 32'(busy), 0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        cmp_en = 1;
        @(negedge clk);

        op1(4'h2, 8'hFF, 8'h01);
        lit("add_ff_01", 8'h00, 1, 0, 1, 1);
        chk("add_ff_01.busy", 32'(busy), 0);
        op1(4'h8, 8'h80, 8'h01);
        lit("sub_80_01", 8'h7F, 0, 1, 0, 1);
        op1(4'h8, 8'h01, 8'h02);
        lit("sub_01_02", 8'hFF, 1, 0, 0, 1);
        op1(4'h1, 8'h00, 8'h55);
        lit("op1_00_55", 8'h00, 0, 0, 1, 1);
        op1(4'h5, 8'h00, 8'h55);
        lit("ldb_00_55", 8'h55, 0, 0, 0, 1);

        // Consecutive requests, one per edge.
        for (int i = 0; i < 6; i++) begin
            start = 1'b1; alu_op = b2b_op[i]; inA = b2b_a[i]; inB = b2b_b[i];
            @(negedge clk);
            chk("b2b.alu_out", 32'(alu_out), 32'(b2b_r[i]));
            chk("b2b.done", 32'(done), 1);
        end
        start = 1'b0;
        @(negedge clk);
        chk("hold.done", 32'(done), 0);
        chk("hold.alu_out", 32'(alu_out), 0);
        chk("hold.SKZ_cmp", 32'(SKZ_cmp), 1);

        run_mul(8'h0F, 8'h11, 1'b0, nb, nd);
        chk("mul_0f_11.busy_cycles", nb, 8);
        chk("mul_0f_11.done_pulses", nd, 1);
        lit("mul_0f_11", 8'hFF, 0, 0, 0, 0);
        run_mul(8'h10, 8'h10, 1'b0, nb, nd);
        chk("mul_10_10.done_pulses", nd, 1);
        lit("mul_10_10", 8'h00, 1, 0, 1, 0);
        run_mul(8'h03, 8'h05, 1'b1, nb, nd);
        chk("mul_inject.busy_cycles", nb, 8);
        chk("mul_inject.done_pulses", nd, 1);
        lit("mul_inject", 8'h0F, 0, 0, 0, 0);

        // Abort a multiply with reset partway through.
        start = 1'b1; alu_op = 4'hA; inA = 8'h0F; inB = 8'h11;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        chk("abort.busy_before", 32'(busy), 1);
        #2 rst_n = 1'b0;
        #1;
        lit("abort", 0, 0, 0, 0, 0);
        chk("abort.busy", 32'(busy), 0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        nd = 0;
        repeat (12) begin
            @(negedge clk);
            if (done) nd++;
        end
        chk("abort.done_pulses", nd, 0);
        chk("abort.alu_out", 32'(alu_out), 0);

        op1(4'h2, 8'h12, 8'h34);
        lit("add_12_34", 8'h46, 0, 0, 0, 1);
        op1(4'h2, 8'h7F, 8'h01);
        lit("add_7f_01", 8'h80, 0, 1, 0, 1);
        op1(4'hB, 8'h81, 8'h08);
        lit("shl_81_8", 8'h00, 1, 0, 1, 1);
        op1(4'hB, 8'h81, 8'h09);
        lit("shl_81_9", 8'h00, 0, 0, 1, 1);
        op1(4'hB, 8'h81, 8'h00);
        lit("shl_81_0", 8'h81, 0, 0, 0, 1);
        op1(4'hC, 8'h80, 8'h07);
        lit("shr_80_7", 8'h01, 0, 0, 0, 1);
        op1(4'hC, 8'hFF, 8'h08);
        lit("shr_ff_8", 8'h00, 0, 0, 1, 1);
        op1(4'hE, 8'h00, 8'hAA);
        lit("op_e_pass", 8'h00, 0, 0, 1, 1);
        repeat (2) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_seq.md
ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 Parameter: WIDTH, default 8, datapath width in bits; legal range 4..32.
REQ-002 Port: clk  input  1  single clock; all state updates on its rising edge.
REQ-003 Port: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 Port: start  input  1  operation request; sampled on a rising edge while idle.
REQ-005 Port: alu_op  input  4  operation code, captured with start.
REQ-006 Port: inA  input  WIDTH  operand A (accumulator side), captured with start.
REQ-007 Port: inB  input  WIDTH  operand B (memory side), captured with start.
REQ-008 Port: busy  output  1  high while a multi-cycle operation is in progress.
REQ-009 Port: done  output  1  one-cycle pulse when alu_out and the flags are updated.
REQ-010 Port: alu_out  output  WIDTH  registered result.
REQ-011 Port: SKZ_cmp  output  1  registered zero flag for the skip-if-zero decision.
REQ-012 Port: carry  output  1  registered carry/borrow/overflow-of-width flag.
REQ-013 Port: ovf  output  1  registered signed-overflow flag.

Function
REQ-014 States: IDLE, MUL; the block leaves IDLE only for op 1010 (MUL).
REQ-015 Opcodes (result): 0000, 0001, 0110, 0111, 1101-1111 -> A; 0010 -> A+B; 0011 -> A&B; 0100 -> A^B; 0101 -> B; 1000 -> A-B; 1001 -> A|B; 1010 -> A*B (low WIDTH bits); 1011 -> A<<B; 1100 -> A>>B (logical).
REQ-016 Single-cycle ops: start high in IDLE at edge N updates alu_out and the flags at edge N; done is high for the cycle after edge N; busy stays low.
REQ-017 Back-to-back single-cycle ops are accepted on consecutive edges, each producing its own done pulse.
REQ-018 MUL: start in IDLE at edge N sets busy; the shift-add iteration runs one operand bit per cycle; at edge N+WIDTH the result and flags are written, busy falls and done pulses for one cycle.
REQ-019 start is ignored while busy; operands and alu_op are not re-captured until IDLE.
REQ-020 carry: ADD = carry-out of bit WIDTH-1; SUB = 1 when A<B unsigned (borrow); MUL = 1 when any bit of the upper WIDTH product bits is set; SHL = last bit shifted out (0 if B=0); 0 for all other ops.
REQ-021 ovf: ADD/SUB = two's-complement signed overflow; 0 for all other ops.
REQ-022 Shifts: when B >= WIDTH the result is 0; for SHL, carry is 0 when B > WIDTH and A[0] when B = WIDTH.
REQ-023 SKZ_cmp: NOR of all bits of A for ops 0000, 0001, 0110, 0111; otherwise NOR of all result bits; written together with alu_out.
REQ-024 alu_out, SKZ_cmp, carry and ovf hold their values between operations.
REQ-025 Arithmetic wraps modulo 2^WIDTH; no saturation.

Reset
REQ-026 rst_n low asynchronously forces IDLE: busy=0, done=0, alu_out=0, SKZ_cmp=0, carry=0, ovf=0, and clears internal operand and product registers.
REQ-027 Reset during MUL aborts the operation: no done pulse, and alu_out stays 0 after release.
REQ-028 The first start is accepted on the first rising edge with rst_n high.

Verification (WIDTH=8)
REQ-029 ADD with A=0xFF, B=0x01 -> alu_out=0x00, carry=1, ovf=0, SKZ_cmp=1, done one cycle later, busy never high.
REQ-030 SUB with A=0x80, B=0x01 -> alu_out=0x7F, carry=0, ovf=1; SUB with A=0x01, B=0x02 -> alu_out=0xFF, carry=1.
REQ-031 MUL with A=0x0F, B=0x11 -> busy high 8 cycles, then alu_out=0xFF, carry=0, done single pulse; MUL with A=0x10, B=0x10 -> alu_out=0x00, carry=1, SKZ_cmp=1.
REQ-032 MUL in progress; start ADD with A=0x01, B=0x01 at cycle 3 -> ignored: the MUL result alone appears and there is exactly one done pulse.
REQ-033 Op 0001 with A=0x00, B=0x55 -> SKZ_cmp=1, alu_out=0x00; op 0101 with A=0x00, B=0x55 -> SKZ_cmp=0, alu_out=0x55.
REQ-034 rst_n pulsed low at MUL cycle 4 -> all outputs 0 immediately, no done pulse; an ADD issued after release completes normally; SHL with A=0x81, B=8 -> alu_out=0x00, carry=1.
